// File: rtl/ysyx_22050854_pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050854_pc_pkg : shared constants and helpers for fetch PC/BTB |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package ysyx_22050854_pc_pkg;

    localparam int unsigned DEF_XLEN      = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic logic [1:0] cnt_inc(input logic [1:0] c);
        return (c == CNT_ST) ? CNT_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] cnt_dec(input logic [1:0] c);
        return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
    endfunction

    function automatic int unsigned idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // Instruction-aligned PCs: bits [1:0] belong to neither index nor tag.
    function automatic int unsigned tag_w(input int unsigned xlen, input int unsigned entries);
        return xlen - $clog2(entries) - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050854_btb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050854_btb : direct-mapped BTB, combinational lookup,         |
// | synchronous training, async clear of valid bits. Revision 1.0        |
// +----------------------------------------------------------------------+
module ysyx_22050854_btb
    import ysyx_22050854_pc_pkg::*;
#(
    parameter int unsigned XLEN    = DEF_XLEN,
    parameter int unsigned ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lkp_pc_i,
    output logic            lkp_hit_o,
    output logic [1:0]      lkp_cnt_o,
    output logic [XLEN-1:0] lkp_target_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [XLEN-1:0] upd_target_i
);

    localparam int unsigned IDX_W = idx_w(ENTRIES);
    localparam int unsigned TAG_W = tag_w(XLEN, ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic [IDX_W-1:0] w_lkp_idx, w_upd_idx;
    logic [TAG_W-1:0] w_lkp_tag, w_upd_tag;
    logic             w_upd_hit;
    logic             wr_en_d;
    logic [TAG_W-1:0] tag_d;
    logic [XLEN-1:0]  target_d;
    logic [1:0]       cnt_d;
    logic             w_unused_lsb;

    assign w_lkp_idx    = lkp_pc_i[IDX_W+1:2];
    assign w_lkp_tag    = lkp_pc_i[XLEN-1:IDX_W+2];
    assign w_upd_idx    = upd_pc_i[IDX_W+1:2];
    assign w_upd_tag    = upd_pc_i[XLEN-1:IDX_W+2];
    assign w_unused_lsb = ^{lkp_pc_i[1:0], upd_pc_i[1:0]};

    // Reads see the arrays before this edge's write: no write-to-read bypass.
    assign lkp_hit_o    = valid_q[w_lkp_idx] && (tag_q[w_lkp_idx] == w_lkp_tag);
    assign lkp_cnt_o    = cnt_q[w_lkp_idx];
    assign lkp_target_o = target_q[w_lkp_idx];

    assign w_upd_hit = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);

    always_comb begin
        wr_en_d  = 1'b0;
        tag_d    = tag_q[w_upd_idx];
        target_d = target_q[w_upd_idx];
        cnt_d    = cnt_q[w_upd_idx];
        if (upd_valid_i) begin
            if (w_upd_hit) begin
                wr_en_d = 1'b1;
                if (upd_taken_i) begin
                    cnt_d    = cnt_inc(cnt_q[w_upd_idx]);
                    target_d = upd_target_i;
                end else begin
                    cnt_d = cnt_dec(cnt_q[w_upd_idx]);
                end
            end else if (upd_taken_i) begin
                wr_en_d  = 1'b1;
                tag_d    = w_upd_tag;
                target_d = upd_target_i;
                cnt_d    = CNT_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en_d) begin
            valid_q[w_upd_idx] <= 1'b1;
        end
    end

    // Payload is left unreset; a cleared valid bit makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            tag_q[w_upd_idx]    <= tag_d;
            target_q[w_upd_idx] <= target_d;
            cnt_q[w_upd_idx]    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050854_pc_btb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050854_pc_btb : fetch PC register and next-PC select; the BTB |
// | predictor is built only when YSYX_PC_BTB_EN is defined. Rev 1.0      |
// +----------------------------------------------------------------------+
module ysyx_22050854_pc_btb
    import ysyx_22050854_pc_pkg::*;
#(
    parameter int unsigned     XLEN        = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEF_RESET_VEC),
    parameter int unsigned     BTB_ENTRIES = 8,
    parameter int unsigned     INST_BYTES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            btb_hit
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_btb_target;
    logic [1:0]      w_btb_cnt;
    logic            w_btb_hit;
    logic            w_unused_rpc;

    assign w_seq_pc     = pc_q + XLEN'(INST_BYTES);
    assign w_unused_rpc = ^redirect_pc[1:0];

`ifdef YSYX_PC_BTB_EN
    ysyx_22050854_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lkp_pc_i     (pc_q),
        .lkp_hit_o    (w_btb_hit),
        .lkp_cnt_o    (w_btb_cnt),
        .lkp_target_o (w_btb_target),
        .upd_valid_i  (upd_valid),
        .upd_pc_i     (upd_pc),
        .upd_taken_i  (upd_taken),
        .upd_target_i (upd_target)
    );
`else
    logic w_unused_upd;

    assign w_btb_hit    = 1'b0;
    assign w_btb_cnt    = CNT_SNT;
    assign w_btb_target = w_seq_pc;
    assign w_unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target};
`endif

    assign btb_hit     = w_btb_hit;
    assign pred_taken  = w_btb_hit && w_btb_cnt[1];
    assign pred_target = pred_taken ? w_btb_target : w_seq_pc;
    assign pc          = pc_q;

    // Redirect beats stall; pred_target already folds in the sequential fallback.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (!stall) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050854_pc_btb.sv
`default_nettype none
// Self-checking bench for ysyx_22050854_pc_btb: directed table, hand sequences,
// and randomized traffic against an array-based reference model.
module tb_ysyx_22050854_pc_btb;

`ifdef YSYX_PC_BTB_EN
    localparam bit BTB_EN = 1'b1;
`else
    localparam bit BTB_EN = 1'b0;
`endif
    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, upd_valid, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [31:0] pc, pred_target;
    logic        pred_taken, btb_hit;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ysyx_22050854_pc_btb #(
        .XLEN        (32),
        .RESET_VEC   (RV),
        .BTB_ENTRIES (8),
        .INST_BYTES  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .btb_hit        (btb_hit)
    );

    // Reference model: 8 entries, index = word address mod 8, tag = pc / 32.
    bit          m_valid [8];
    logic [31:0] m_tag   [8];
    logic [31:0] m_tgt   [8];
    int          m_cnt   [8];
    logic [31:0] m_pc;

    function automatic int ix(input logic [31:0] a);
        return int'((a >> 2) % 8);
    endfunction

    task automatic m_reset();
        m_pc = RV;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic m_look(output bit h, output bit t, output logic [31:0] tg);
        int i;
        i  = ix(m_pc);
        h  = BTB_EN && m_valid[i] && (m_tag[i] == (m_pc >> 5));
        t  = h && (m_cnt[i] >= 2);
        tg = t ? m_tgt[i] : m_pc + 32'd4;
    endtask

    task automatic m_edge();
        bit h, t, uh;
        logic [31:0] tg;
        int i;
        if (!rst) begin
            m_reset();
            return;
        end
        m_look(h, t, tg);
        if (BTB_EN && upd_valid) begin
            i  = ix(upd_pc);
            uh = m_valid[i] && (m_tag[i] == (upd_pc >> 5));
            if (uh && upd_taken) begin
                m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                m_tgt[i] = upd_target;
            end else if (uh) begin
                m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = upd_pc >> 5;
                m_tgt[i]   = upd_target;
                m_cnt[i]   = 2;
            end
        end
        if (redirect_valid)  m_pc = redirect_pc & ~32'd3;
        else if (!stall)     m_pc = tg;
    endtask

    task automatic step();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_exp(input string name, input logic [31:0] epc, input bit eh,
                             input bit et, input logic [31:0] etg);
        n_total++;
        if (pc === epc && btb_hit === eh && pred_taken === et && pred_target === etg)
            n_pass++;
        else
            $display("FAIL %s: got pc=%h hit=%b taken=%b tgt=%h, expected pc=%h hit=%b taken=%b tgt=%h",
                     name, pc, btb_hit, pred_taken, pred_target, epc, eh, et, etg);
    endtask

    task automatic check_model(input string name);
        bit h, t;
        logic [31:0] tg;
        m_look(h, t, tg);
        check_exp(name, m_pc, h, t, tg);
    endtask

    typedef struct {
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h0,         32'h8000_0004};
        tbl[1] = '{1'b0, 1'b0, 32'h0,         32'h8000_0008};
        tbl[2] = '{1'b0, 1'b0, 32'h0,         32'h8000_000C};
        tbl[3] = '{1'b1, 1'b0, 32'h0,         32'h8000_000C};
        tbl[4] = '{1'b1, 1'b0, 32'h0,         32'h8000_000C};
        tbl[5] = '{1'b1, 1'b0, 32'h0,         32'h8000_000C};
        tbl[6] = '{1'b1, 1'b1, 32'h8000_0103, 32'h8000_0100};
        tbl[7] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        tbl[8] = '{1'b0, 1'b0, 32'h0,         32'h0000_0000};
        tbl[9] = '{1'b0, 1'b1, 32'h8000_0002, 32'h8000_0000};

        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        m_reset();
        step();
        step();
        check_exp("reset", RV, 1'b0, 1'b0, RV + 32'd4);
        rst = 1'b1;

        for (int k = 0; k < 10; k++) begin
            stall = tbl[k].stall;
            redirect_valid = tbl[k].redir;
            redirect_pc = tbl[k].rpc;
            step();
            check_exp($sformatf("vec%0d", k), tbl[k].exp_pc, 1'b0, 1'b0, tbl[k].exp_pc + 32'd4);
            check_model($sformatf("vec%0d_model", k));
        end
        stall = 1'b0; redirect_valid = 1'b0;

        // Train 0x80000010 -> 0x80000040, then walk up to it.
        upd_valid = 1'b1; upd_pc = 32'h8000_0010; upd_taken = 1'b1; upd_target = 32'h8000_0040;
        step();
        upd_valid = 1'b0;
        step(); step(); step();
        check_exp("train_hit", 32'h8000_0010, BTB_EN, BTB_EN,
                  BTB_EN ? 32'h8000_0040 : 32'h8000_0014);
        step();
        check_exp("train_next", BTB_EN ? 32'h8000_0040 : 32'h8000_0014, 1'b0, 1'b0,
                  BTB_EN ? 32'h8000_0044 : 32'h8000_0018);

        // Hysteresis while parked at 0x80000010.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0010;
        step();
        redirect_valid = 1'b0;
        upd_valid = 1'b1; upd_pc = 32'h8000_0010; upd_taken = 1'b0;
        step();
        check_exp("nt_wnt", 32'h8000_0010, BTB_EN, 1'b0, 32'h8000_0014);
        step();
        check_exp("nt_snt", 32'h8000_0010, BTB_EN, 1'b0, 32'h8000_0014);
        upd_taken = 1'b1; upd_target = 32'h8000_0060;
        step();
        check_exp("t_wnt", 32'h8000_0010, BTB_EN, 1'b0, 32'h8000_0014);
        step();
        check_exp("t_wt", 32'h8000_0010, BTB_EN, BTB_EN,
                  BTB_EN ? 32'h8000_0060 : 32'h8000_0014);

        // Same-index allocation during lookup: this cycle still sees the old entry.
        stall = 1'b0; upd_pc = 32'h8000_0030; upd_target = 32'h8000_0080;
        #1;
        check_exp("alias_pre", 32'h8000_0010, BTB_EN, BTB_EN,
                  BTB_EN ? 32'h8000_0060 : 32'h8000_0014);
        step();
        upd_valid = 1'b0;
        check_model("alias_next");
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0010;
        step();
        check_exp("alias_old_miss", 32'h8000_0010, 1'b0, 1'b0, 32'h8000_0014);
        redirect_pc = 32'h8000_0030;
        step();
        redirect_valid = 1'b0;
        check_exp("alias_new_hit", 32'h8000_0030, BTB_EN, BTB_EN,
                  BTB_EN ? 32'h8000_0080 : 32'h8000_0034);

        // Saturation at strong-taken: 3 taken then 1 not-taken stays predicted taken.
        upd_valid = 1'b1; upd_taken = 1'b1;
        step(); step(); step();
        upd_taken = 1'b0;
        step();
        check_exp("sat_hi", 32'h8000_0030, BTB_EN, BTB_EN,
                  BTB_EN ? 32'h8000_0080 : 32'h8000_0034);
        upd_valid = 1'b0; stall = 1'b0;

        for (int c = 0; c < 400; c++) begin
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 5) == 0);
            redirect_pc    = 32'h8000_0000 | $urandom_range(0, 255);
            upd_valid      = $urandom_range(0, 1) == 1;
            upd_pc         = 32'h8000_0000 | ($urandom_range(0, 63) << 2);
            upd_taken      = $urandom_range(0, 2) != 0;
            upd_target     = 32'h8000_0000 | ($urandom_range(0, 63) << 2);
            if (c == 200) begin
                rst = 1'b0;
                m_reset();
                #1;
                check_model("async_rst");
            end
            if (c == 203) rst = 1'b1;
            step();
            check_model($sformatf("rand%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
